// File: rtl/mips_pkg.sv
// Shared definitions for the P5 MIPS front end: reset/memory defaults,
// the canonical nop encoding and the IF/ID pipeline bundle.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
  localparam logic [31:0] IMEM_BASE_DEF = 32'h0000_3000;
  localparam int unsigned IMEM_WORDS_DEF = 4096;

  // sll $0, $0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        valid;
    logic        exc;
  } ifid_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register with next-PC priority: reset > stall > redirect > pc+4.
module fetch_pc_gen
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_f
);

  logic [31:0] pc_q;

  // PC update; a redirect coinciding with a stall is dropped, the D stage re-asserts it
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (!stall) begin
      if (redirect_valid) begin
        pc_q <= redirect_pc;
      end else begin
        pc_q <= pc_q + 32'd4;
      end
    end
  end

  assign pc_f = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the PC to the instruction ROM and captures
// the returned word into the IF/ID register. Delay slots are never flushed.
// Optional macro FETCH_CHECK_EN: keeps redirect targets unaligned and flags
// misaligned or out-of-range fetches on fetch_exc_d.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] IMEM_BASE  = IMEM_BASE_DEF,
  parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
`ifdef FETCH_CHECK_EN
  output logic        fetch_exc_d,
`endif
  output logic        valid_d
);

  logic [31:0] pc_f;
  logic [31:0] redirect_target;
  logic        fetch_fault;
  ifid_t       ifid_q;
  ifid_t       ifid_next;

`ifdef FETCH_CHECK_EN
  localparam logic [32:0] IMEM_LO = {1'b0, IMEM_BASE};
  localparam logic [32:0] IMEM_HI = {1'b0, IMEM_BASE} + 33'(IMEM_WORDS) * 33'd4;

  assign redirect_target = redirect_pc;

  // Range compare in 33 bits so a window ending at 2^32 does not wrap
  always_comb begin
    fetch_fault = 1'b0;
    if (pc_f[1:0] != 2'b00) fetch_fault = 1'b1;
    if ({1'b0, pc_f} < IMEM_LO) fetch_fault = 1'b1;
    if ({1'b0, pc_f} >= IMEM_HI) fetch_fault = 1'b1;
  end

  assign fetch_exc_d = ifid_q.exc;
`else
  logic [66:0] unused_cfg;

  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign fetch_fault     = 1'b0;
  assign unused_cfg      = {redirect_pc[1:0], ifid_q.exc, IMEM_BASE, 32'(IMEM_WORDS)};
`endif

  fetch_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_target),
    .pc_f           (pc_f)
  );

  assign imem_addr = pc_f;

  // Next IF/ID contents; a faulting fetch is replaced by a nop
  always_comb begin
    ifid_next       = '0;
    ifid_next.instr = fetch_fault ? NOP_INSTR : imem_instr;
    ifid_next.pc    = pc_f;
    ifid_next.pc8   = pc_f + 32'd8;
    ifid_next.valid = 1'b1;
    ifid_next.exc   = fetch_fault;
  end

  // IF/ID register: cleared on reset, frozen under stall
  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_q       <= '0;
      ifid_q.instr <= NOP_INSTR;
    end else if (!stall) begin
      ifid_q <= ifid_next;
    end
  end

  assign instr_d = ifid_q.instr;
  assign pc_d    = ifid_q.pc;
  assign pc8_d   = ifid_q.pc8;
  assign valid_d = ifid_q.valid;

endmodule
